mux2_rr_arbiter: RTL
====================

Name: mux2_rr_arbiter

Overview:
- Arbitrates two valid/ready requesters (A, B) onto one shared output channel through a 2:1 select datapath.
- Selection follows the lab multiplexer convention: out = sel ? b : a.
- Round-robin fairness; registered output stage; per-source beat counters for debug and verification.
- Sits in front of any single-consumer resource that is shared by two producers.

Parameters:
- WIDTH, 8, data width of each channel.
- CNT_W, 16, width of the per-source accepted-beat counters.
- BURST_LEN, 4, maximum consecutive grants to one source; used only with MUX2_ARB_BURST_EN.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- a_valid  in  1  requester A has data.
- a_data  in  WIDTH  requester A payload.
- a_ready  out  1  A beat accepted this cycle.
- b_valid  in  1  requester B has data.
- b_data  in  WIDTH  requester B payload.
- b_ready  out  1  B beat accepted this cycle.
- out_valid  out  1  output register holds a beat.
- out_data  out  WIDTH  registered payload.
- out_src  out  1  source of held beat (0=A, 1=B).
- out_ready  in  1  consumer accepts the beat.
- sel  out  1  combinational mux select for the current grant (0=A, 1=B).
- cnt_a  out  CNT_W  beats accepted from A.
- cnt_b  out  CNT_W  beats accepted from B.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_src=0, cnt_a=cnt_b=0, last=1 (so A wins the first tie), FSM=EMPTY.
- FSM has two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- load_en = (state==EMPTY) | out_ready.
- Grant (combinational):
  - Only A valid -> A.
  - Only B valid -> B.
  - Both valid -> the source not equal to last.
  - Neither valid -> no grant; sel holds its previous registered value.
- a_ready = load_en & grant_a; b_ready = load_en & grant_b. At most one is high in any cycle.
- On accept: out_data <= sel ? b_data : a_data; out_src <= sel; last <= sel; the matching cnt increments; state -> FULL.
- FULL & out_ready & no grant -> EMPTY.
- FULL & out_ready & grant -> stays FULL with the new beat. Back-to-back throughput is 1 beat/cycle.
- FULL & !out_ready -> all outputs held stable; a_ready=b_ready=0.
- Latency: input accept to out_valid is 1 cycle.
- Counters wrap modulo 2^CNT_W with no saturation.
- Inputs are not required to hold valid after a cycle with ready low. The arbiter re-evaluates the grant every cycle and never locks a grant while data is unaccepted.
- Reset asserted mid-transfer: the held beat is dropped, out_valid falls asynchronously, and counters clear.
- X on a_data/b_data of a non-granted source must not propagate to out_data.

Optional Feature:
- Macro: MUX2_ARB_BURST_EN.
- Defined:
  - A burst counter lets the last-granted source keep the grant while its valid stays high, up to BURST_LEN consecutive accepts.
  - After BURST_LEN accepts, the other source wins if it is valid.
  - The counter resets to 0 when the grant switches or when the current source drops valid.
  - The counter clears on reset.
- Undefined: strict alternation on every contended cycle; no burst counter logic is instantiated.

Decomposition:
- Shared package mux2_arb_pkg:
  - state enum {ST_EMPTY, ST_FULL}.
  - Source constants SRC_A=1'b0, SRC_B=1'b1.
  - Default WIDTH and CNT_W localparams.
- One natural sub-module: mux2_rr_grant, the combinational grant/sel logic taking a_valid, b_valid, last and the burst status. It is reused for the burst variant.
- The datapath select is an inline 2:1 mux (sel ? b : a).

Test Plan:
- Reset: rst_n=0 mid-FULL with out_data=8'h5A -> out_valid=0, out_data=0, cnt_a=cnt_b=0 immediately, without waiting for a clock edge.
- Single source: A streams 8'h01..8'h04 with out_ready=1 -> out_data 01,02,03,04 on consecutive cycles, out_src=0, cnt_a=4.
- Contention (macro off): A and B are always valid, A data 8'hA0+n, B data 8'hB0+n -> output sequence A0,B0,A1,B1,...; first beat is from A.
- Backpressure: out_ready=0 for 3 cycles with FULL=8'h33 -> out_data stays 33, a_ready=b_ready=0; on out_ready=1 the next beat loads the same cycle.
- Burst (macro on, BURST_LEN=4): both always valid -> four A beats, then four B beats, then four A beats; dropping a_valid after 2 beats switches to B the next cycle.
- Counter wrap: CNT_W=4, 17 A beats -> cnt_a=1.

Source files
------------

// File: rtl/mux2_arb_pkg.sv
// mux2_arb_pkg: shared state encoding, source ids and default sizes for the 2:1 round-robin arbiter
package mux2_arb_pkg;

    typedef enum logic {ST_EMPTY, ST_FULL} state_t;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_CNT_W     = 16;
    localparam int DEF_BURST_LEN = 4;

endpackage

// File: rtl/mux2_rr_arbiter_if.sv
// mux2_rr_arbiter_if: two requester channels, the shared output channel and debug counters
interface mux2_rr_arbiter_if
    import mux2_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
);

    logic             a_valid;
    logic [WIDTH-1:0] a_data;
    logic             a_ready;
    logic             b_valid;
    logic [WIDTH-1:0] b_data;
    logic             b_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_src;
    logic             out_ready;
    logic             sel;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;

    modport slave (
        input  a_valid, a_data, b_valid, b_data, out_ready,
        output a_ready, b_ready, out_valid, out_data, out_src, sel, cnt_a, cnt_b
    );

    modport master (
        output a_valid, a_data, b_valid, b_data, out_ready,
        input  a_ready, b_ready, out_valid, out_data, out_src, sel, cnt_a, cnt_b
    );

endinterface

// File: rtl/mux2_rr_grant.sv
// mux2_rr_grant: combinational two-way grant; on a tie the source other than last wins unless hold keeps last
module mux2_rr_grant
    import mux2_arb_pkg::*;
(
    input  logic a_valid,
    input  logic b_valid,
    input  logic last,
    input  logic hold,
    output logic grant_a,
    output logic grant_b
);

    // B wins alone, or on a tie when it is B's turn (alternation) or B is the source being held
    always_comb begin
        grant_b = b_valid & (~a_valid | (hold ? (last == SRC_B) : (last == SRC_A)));
        grant_a = a_valid & ~grant_b;
    end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: round-robin 2:1 arbiter with a one-beat registered output stage and per-source beat counters
// Optional burst grants are enabled by defining MUX2_ARB_BURST_EN.
module mux2_rr_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int BURST_LEN = DEF_BURST_LEN
) (
    input  logic               clk,
    input  logic               rst_n,
    mux2_rr_arbiter_if.slave   bus
);

    state_t state;
    state_t state_nx;
    logic   last;
    logic   sel_q;
    logic   sel;
    logic   hold;
    logic   grant_a;
    logic   grant_b;
    logic   load_en;
    logic   accept;

    if (BURST_LEN < 1) begin : g_bad_burst_len
        $error("BURST_LEN must be at least 1");
    end

    mux2_rr_grant u_grant (
        .a_valid (bus.a_valid),
        .b_valid (bus.b_valid),
        .last    (last),
        .hold    (hold),
        .grant_a (grant_a),
        .grant_b (grant_b)
    );

`ifdef MUX2_ARB_BURST_EN
    localparam int BW = $clog2(BURST_LEN + 1);

    logic [BW-1:0] bcnt;

    // A zero count means no burst is in progress, so the reset tie still goes to A
    assign hold = (bcnt != '0) & (bcnt < BW'(BURST_LEN));

    // Count consecutive accepts of the last source; restart on a switch, clear when that source goes idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bcnt <= '0;
        else if (accept)
            bcnt <= (sel == last) ? ((bcnt == BW'(BURST_LEN)) ? bcnt : bcnt + BW'(1)) : BW'(1);
        else if ((last == SRC_B) ? !bus.b_valid : !bus.a_valid)
            bcnt <= '0;
    end
`else
    assign hold = 1'b0;
`endif

    // Handshakes, mux select and next state; sel keeps its previous value when nobody requests
    always_comb begin
        load_en       = (state == ST_EMPTY) | bus.out_ready;
        sel           = (grant_a | grant_b) ? grant_b : sel_q;
        accept        = load_en & (grant_a | grant_b);
        bus.a_ready   = load_en & grant_a;
        bus.b_ready   = load_en & grant_b;
        bus.sel       = sel;
        bus.out_valid = (state == ST_FULL);
        state_nx      = accept ? ST_FULL : (bus.out_ready ? ST_EMPTY : state);
    end

    // Output stage occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_EMPTY;
        else
            state <= state_nx;
    end

    // Capture the granted beat, remember its source for the next tie, and count it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_data <= '0;
            bus.out_src  <= SRC_A;
            bus.cnt_a    <= '0;
            bus.cnt_b    <= '0;
            last         <= SRC_B;
            sel_q        <= SRC_A;
        end else begin
            sel_q <= sel;
            if (accept) begin
                bus.out_data <= sel ? bus.b_data : bus.a_data;
                bus.out_src  <= sel;
                last         <= sel;
                if (sel)
                    bus.cnt_b <= bus.cnt_b + CNT_W'(1);
                else
                    bus.cnt_a <= bus.cnt_a + CNT_W'(1);
            end
        end
    end

endmodule
